i2c_target_regif: RTL and testbench

//  I2C target (slave) endpoint, 7-bit addressing, standard/fast mode. Bench-side and SoC-side peer of the APB I2C master.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_cond_detect.sv | 111 +++++++++++
 rtl/i2c_target_regif.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_target_regif.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, synchroniser depth.
package i2c_pkg;

    localparam logic        I2C_ACK     = 1'b0;
    localparam logic        I2C_NACK    = 1'b1;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic        RW_READ     = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRreq,
        StRload,
        StRdata,
        StRdataAck
    } tgt_state_e;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus condition detector: synchronises SCL/SDA, optionally glitch-filters them
// (I2C_TGT_GLITCH_FILTER_EN), and flags SCL edges plus START/STOP conditions.
module i2c_bus_cond_detect
    import i2c_pkg::*;
#(
    parameter int unsigned FILT_DEPTH = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_raw, sda_raw;
    logic                   scl_f, sda_f;
    logic                   scl_prev_q, sda_prev_q;

    // Synchroniser shift
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end

    // Synchroniser flops reset to the idle-high bus level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign scl_raw = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int unsigned CntW = $clog2(FILT_DEPTH + 1);

    logic [CntW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic            scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    // Filter output follows input only after FILT_DEPTH consecutive differing samples
    always_comb begin
        scl_filt_d = scl_filt_q;
        scl_cnt_d  = '0;
        sda_filt_d = sda_filt_q;
        sda_cnt_d  = '0;
        if (scl_raw != scl_filt_q) begin
            if (scl_cnt_q == CntW'(FILT_DEPTH - 1)) scl_filt_d = scl_raw;
            else                                    scl_cnt_d  = scl_cnt_q + CntW'(1);
        end
        if (sda_raw != sda_filt_q) begin
            if (sda_cnt_q == CntW'(FILT_DEPTH - 1)) sda_filt_d = sda_raw;
            else                                    sda_cnt_d  = sda_cnt_q + CntW'(1);
        end
    end

    // Filter state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    logic unused_filt_depth;
    assign unused_filt_depth = ^FILT_DEPTH;
    assign scl_f = scl_raw;
    assign sda_f = sda_raw;
`endif

    // Previous-sample flops for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    // Edge and bus-condition decode
    always_comb begin
        sda_s     = sda_f;
        scl_rise  = scl_f & ~scl_prev_q;
        scl_fall  = ~scl_f & scl_prev_q;
        start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
        stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    end

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target register interface: 7-bit address, pointer byte, strobed writes, pointer
// reads with auto-increment. Optional input glitch filter via I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_regif
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned PTR_W      = 8,
    parameter int unsigned FILT_DEPTH = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic [ADDR_W-1:0] own_addr,
    output logic [PTR_W-1:0]  reg_ptr,
    output logic              wr_en,
    output logic [7:0]        wr_data,
    input  logic [7:0]        rd_data,
    output logic              rd_req,
    output logic              busy
);

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    tgt_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [PTR_W-1:0] reg_ptr_q, reg_ptr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_req_q, rd_req_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       bit_full, addr_hit;

    i2c_bus_cond_detect #(
        .FILT_DEPTH(FILT_DEPTH)
    ) u_cond (
        .clk      (clk),
        .resetn   (resetn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign bit_full = (bit_cnt_q == 4'd8);
    // General call (address 0) is never acknowledged
    assign addr_hit = (shift_q[7:1] == own_addr) && (shift_q[7:1] != '0);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic; STOP/START override any bit in progress
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = StIdle;
        end else if (start_det) begin
            state_d = StAddr;
        end else begin
            unique case (state_q)
                StAddr:     if (scl_fall && bit_full) state_d = addr_hit ? StAddrAck : StIdle;
                StAddrAck:  if (scl_fall) state_d = (rw_q == RW_READ) ? StRreq : StPtr;
                StPtr:      if (scl_fall && bit_full) state_d = StPtrAck;
                StPtrAck:   if (scl_fall) state_d = StWdata;
                StWdata:    if (scl_fall && bit_full) state_d = StWdataAck;
                StWdataAck: if (scl_fall) state_d = StWdata;
                StRreq:     state_d = StRload;
                StRload:    state_d = StRdata;
                StRdata:    if (scl_fall && bit_cnt_q == 4'd7) state_d = StRdataAck;
                StRdataAck: if (scl_fall) state_d = (ack_q == I2C_ACK) ? StRreq : StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Datapath next values: shifter, bit counter, pointer, strobes, SDA drive
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        reg_ptr_d = reg_ptr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        rd_req_d  = 1'b0;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        if (stop_det || start_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise && !bit_full) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == StWdata && bit_cnt_q == 4'd7) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {shift_q[6:0], sda_s};
                        end
                    end
                    if (scl_fall && bit_full) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            rw_d     = shift_q[0];
                            sda_oe_d = addr_hit;
                            busy_d   = addr_hit;
                        end else begin
                            sda_oe_d = 1'b1;
                            if (state_q == StPtr) reg_ptr_d = PTR_W'(shift_q);
                        end
                    end
                end
                StAddrAck: begin
                    // For reads the ACK is held until the first data bit is loaded
                    if (scl_fall) begin
                        if (rw_q == RW_READ) rd_req_d = 1'b1;
                        else                 sda_oe_d = 1'b0;
                    end
                end
                StPtrAck: if (scl_fall) sda_oe_d = 1'b0;
                StWdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        reg_ptr_d = reg_ptr_q + PTR_W'(1);
                    end
                end
                StRload: begin
                    shift_d   = rd_data;
                    sda_oe_d  = ~rd_data[7];
                    bit_cnt_d = '0;
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) ack_d = sda_s;
                    if (scl_fall && ack_q == I2C_ACK) begin
                        reg_ptr_d = reg_ptr_q + PTR_W'(1);
                        rd_req_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sda_oe_q  <= 1'b0;
            reg_ptr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            ack_q     <= I2C_NACK;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            reg_ptr_q <= reg_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        sda_oe  = sda_oe_q;
        reg_ptr = reg_ptr_q;
        wr_en   = wr_en_q;
        wr_data = wr_data_q;
        rd_req  = rd_req_q;
        busy    = busy_q;
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged I2C controller, transaction-level model of the
// register pointer, expected write/read-request queues and per-cycle output checks.
module tb_i2c_target_regif;

    localparam int Q = 8;  // quarter SCL period in clk cycles
    localparam logic [6:0] OWN = 7'h50;
`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam logic [7:0] GLITCH_WR   = 8'hA5;
    localparam logic       GLITCH_ACK  = 1'b0;
`else
    localparam logic [7:0] GLITCH_WR   = 8'hA2;
    localparam logic       GLITCH_ACK  = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       scl_drv, sda_drv;
    logic       sda_oe, wr_en, rd_req, busy;
    logic [7:0] reg_ptr, wr_data, rd_data;
    wire        sda_line = sda_drv & ~sda_oe;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] wr_log[$];
    logic [7:0]  got_rd[$];
    logic [7:0]  wq[$];
    logic [7:0]  m_ptr;

    logic oe_prev = 1'b0;
    int   hi_cnt  = 0;

    always #5 clk = ~clk;

    // Register file responder: each location reads back as its address inverted
    assign rd_data = reg_ptr ^ 8'hFF;

    i2c_target_regif dut (
        .clk     (clk),
        .resetn  (resetn),
        .scl_i   (scl_drv),
        .sda_i   (sda_line),
        .sda_oe  (sda_oe),
        .own_addr(OWN),
        .reg_ptr (reg_ptr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_req  (rd_req),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: strobes against expected queues, SDA drive steady during SCL high
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (wr_en) begin
                wr_log.push_back({reg_ptr, wr_data});
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected actual=%0h required=none", {reg_ptr, wr_data});
                end else begin
                    check("wr_event", {reg_ptr, wr_data}, exp_wr.pop_front());
                end
            end
            if (rd_req) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_req_unexpected actual=%0h required=none", reg_ptr);
                end else begin
                    check("rd_req_ptr", reg_ptr, exp_rd.pop_front());
                end
            end
            if (scl_drv && hi_cnt >= 5) check("sda_oe_stable_scl_high", sda_oe, oe_prev);
        end
        oe_prev = sda_oe;
        hi_cnt  = scl_drv ? hi_cnt + 1 : 0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, input bit glitch, output logic line);
        wait_clk(Q);
        sda_drv = b;
        wait_clk(Q);
        scl_drv = 1'b1;
        if (glitch) begin
            wait_clk(3);
            scl_drv = 1'b0;
            wait_clk(2);
            scl_drv = 1'b1;
            wait_clk(Q - 5);
        end else begin
            wait_clk(Q);
        end
        line = sda_line;
        wait_clk(Q);
        scl_drv = 1'b0;
    endtask

    task automatic start_cond();
        wait_clk(Q); sda_drv = 1'b1;
        wait_clk(Q); scl_drv = 1'b1;
        wait_clk(Q); sda_drv = 1'b0;
        wait_clk(Q); scl_drv = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(Q); sda_drv = 1'b0;
        wait_clk(Q); scl_drv = 1'b1;
        wait_clk(Q); sda_drv = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack_line);
        logic l;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == glitch_bit), l);
        clk_bit(1'b1, 1'b0, ack_line);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, l);
            d[i] = l;
        end
        clk_bit(nack, 1'b0, l);
    endtask

    // Address + pointer + bytes from wq; ends with STOP when stop is set or on NACK
    task automatic do_write(input logic [6:0] addr, input logic [7:0] ptr, input bit stop);
        logic l;
        logic [7:0] d;
        bit hit;
        hit = (addr == OWN) && (addr != 7'h00);
        start_cond();
        send_byte({addr, 1'b0}, -1, l);
        check("wr_addr_ack", l, hit ? 1'b0 : 1'b1);
        if (!hit) begin
            check("busy_after_nack", busy, 1'b0);
            check("sda_oe_after_nack", sda_oe, 1'b0);
            stop_cond();
            return;
        end
        check("busy_after_ack", busy, 1'b1);
        send_byte(ptr, -1, l);
        check("ptr_ack", l, 1'b0);
        m_ptr = ptr;
        while (wq.size() > 0) begin
            d = wq.pop_front();
            exp_wr.push_back({m_ptr, d});
            send_byte(d, -1, l);
            check("data_ack", l, 1'b0);
            m_ptr = m_ptr + 8'd1;
        end
        if (stop) begin
            stop_cond();
            check("busy_after_stop", busy, 1'b0);
        end
    endtask

    // Read n bytes from the current pointer, ACK all but the last
    task automatic do_read(input logic [6:0] addr, input int n);
        logic l;
        logic [7:0] d;
        bit hit;
        hit = (addr == OWN) && (addr != 7'h00);
        start_cond();
        send_byte({addr, 1'b1}, -1, l);
        check("rd_addr_ack", l, hit ? 1'b0 : 1'b1);
        if (hit) begin
            exp_rd.push_back(m_ptr);
            for (int i = 0; i < n; i++) begin
                recv_byte((i == n - 1), d);
                got_rd.push_back(d);
                check("rd_data", d, m_ptr ^ 8'hFF);
                if (i < n - 1) begin
                    m_ptr = m_ptr + 8'd1;
                    exp_rd.push_back(m_ptr);
                end
            end
            check("sda_released_after_nack", sda_oe, 1'b0);
        end
        stop_cond();
        check("busy_idle", busy, 1'b0);
    endtask

    initial begin
        logic l;
        int sel, n;
        logic [6:0] a;
        resetn  = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        m_ptr   = 8'h00;
        wait_clk(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_reg_ptr", reg_ptr, 8'h00);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        wait_clk(10);

        // Write pointer then two data bytes
        wr_log.delete();
        wq = '{8'h11, 8'h22};
        do_write(OWN, 8'h10, 1'b1);
        check("t1_wr0", wr_log[0], 16'h1011);
        check("t1_wr1", wr_log[1], 16'h1122);
        check("t1_ptr_end", reg_ptr, 8'h12);

        // Pointer write, repeated START, three-byte read
        got_rd.delete();
        do_write(OWN, 8'h30, 1'b0);
        do_read(OWN, 3);
        check("t2_rd0", got_rd[0], 8'hCF);
        check("t2_rd1", got_rd[1], 8'hCE);
        check("t2_rd2", got_rd[2], 8'hCD);
        check("t2_ptr_end", reg_ptr, 8'h32);

        // Foreign address and general call are NACKed
        wq = '{8'h77};
        do_write(7'h51, 8'h00, 1'b1);
        wq = '{8'h77};
        do_write(7'h00, 8'h00, 1'b1);
        wq.delete();

        // Pointer wrap
        wr_log.delete();
        wq = '{8'hAA, 8'hBB};
        do_write(OWN, 8'hFF, 1'b1);
        check("t4_wr0", wr_log[0], 16'hFFAA);
        check("t4_wr1", wr_log[1], 16'h00BB);
        check("t4_ptr_end", reg_ptr, 8'h01);

        // STOP after four data bits: no write strobe
        wr_log.delete();
        do_write(OWN, 8'h40, 1'b0);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, l);
        stop_cond();
        check("t5_no_wr", wr_log.size(), 0);
        check("t5_sda_oe", sda_oe, 1'b0);
        check("t5_busy", busy, 1'b0);

        // Reset pulse while the target drives a read bit
        do_write(OWN, 8'h80, 1'b0);
        start_cond();
        send_byte({OWN, 1'b1}, -1, l);
        check("t5r_addr_ack", l, 1'b0);
        exp_rd.push_back(m_ptr);
        wait_clk(12);
        check("t5r_driving_msb", sda_oe, 1'b1);
        resetn = 1'b0;
        #1;
        check("t5r_sda_oe", sda_oe, 1'b0);
        check("t5r_busy", busy, 1'b0);
        check("t5r_reg_ptr", reg_ptr, 8'h00);
        check("t5r_rd_req", rd_req, 1'b0);
        check("t5r_wr_en", wr_en, 1'b0);
        wait_clk(3);
        resetn = 1'b1;
        m_ptr = 8'h00;
        wait_clk(Q);
        sda_drv = 1'b1;
        scl_drv = 1'b1;
        wait_clk(2 * Q);

        // SCL glitch inside a data bit
        wr_log.delete();
        start_cond();
        send_byte({OWN, 1'b0}, -1, l);
        check("t6_addr_ack", l, 1'b0);
        send_byte(8'h60, -1, l);
        check("t6_ptr_ack", l, 1'b0);
        m_ptr = 8'h60;
        exp_wr.push_back({8'h60, GLITCH_WR});
        send_byte(8'hA5, 4, l);
        check("t6_data_ack", l, GLITCH_ACK);
        m_ptr = m_ptr + 8'd1;
        stop_cond();
        check("t6_wr_data", wr_log[0], {8'h60, GLITCH_WR});
        check("t6_ptr_end", reg_ptr, 8'h61);

        // Randomised mix of writes, pointer-set reads and current-pointer reads
        for (int t = 0; t < 20; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = OWN;
            else if (sel == 7) a = 7'h00;
            else               a = 7'($urandom_range(1, 127));
            n = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: begin
                    wq.delete();
                    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
                    do_write(a, 8'($urandom), 1'b1);
                end
                1: begin
                    wq.delete();
                    do_write(a, 8'($urandom), 1'b0);
                    do_read(a, n + 1);
                end
                default: do_read(a, n + 1);
            endcase
        end

        wait_clk(10);
        check("end_exp_wr_empty", exp_wr.size(), 0);
        check("end_exp_rd_empty", exp_rd.size(), 0);
        check("end_reg_ptr", reg_ptr, m_ptr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
